wb_port_arbiter: RTL

Shares the single register-file write port between the in-order pipeline writeback path and one long-latency result source (multi-cycle mul/div or late load). The pipeline side presents already-muxed writeback data, from whichever of ALU, immediate, memory or PC+4 was selected. The long-latency side is captured in a one-entry holding register. A registered write port drives the register file one cycle after each grant. An optional aging counter keeps the long-latency source from starving under continuous pipeline traffic.

---
 rtl/wb_port_arbiter.sv | 99 +++++++++
 1 files changed

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs. one held long-latency result.
// Optional anti-starvation aging is compiled in with `define WB_ARB_AGING_EN.
module wb_port_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int AGE_W    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pipe_valid,
  output logic        pipe_ready,
  input  logic [4:0]  pipe_rd,
  input  logic [31:0] pipe_data,
  input  logic        lu_valid,
  output logic        lu_ready,
  input  logic [4:0]  lu_rd,
  input  logic [31:0] lu_data,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        pend_valid,
  output logic [4:0]  pend_rd
);

  // Handshake: a transfer happens in a cycle where valid && ready; ready never depends on valid.
  logic        r_hold_valid;
  logic [4:0]  r_hold_rd;
  logic [31:0] r_hold_data;

  logic w_force;
  logic w_lu_load;
  logic w_grant_pipe;
  logic w_grant_hold;

  assign lu_ready     = !r_hold_valid;
  assign pipe_ready   = !w_force;
  assign w_lu_load    = lu_valid && !r_hold_valid;
  assign w_grant_pipe = pipe_valid && !w_force;
  assign w_grant_hold = r_hold_valid && (w_force || !pipe_valid);
  assign pend_valid   = r_hold_valid;
  assign pend_rd      = r_hold_rd;

`ifdef WB_ARB_AGING_EN
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(MAX_WAIT);

  logic [AGE_W-1:0] r_age;

  assign w_force = r_hold_valid && (r_age == AGE_MAX);

  // Counts cycles the held entry lost arbitration, saturating at the force threshold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_age <= '0;
    end else if (w_lu_load || w_grant_hold) begin
      r_age <= '0;
    end else if (r_hold_valid && (r_age != AGE_MAX)) begin
      r_age <= r_age + AGE_W'(1);
    end
  end
`else
  logic [AGE_W-1:0] w_unused_cfg;

  assign w_force      = 1'b0;
  assign w_unused_cfg = AGE_W'(MAX_WAIT);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_valid <= 1'b0;
      r_hold_rd    <= '0;
      r_hold_data  <= '0;
    end else if (w_grant_hold) begin
      r_hold_valid <= 1'b0;
    end else if (w_lu_load) begin
      r_hold_valid <= 1'b1;
      r_hold_rd    <= lu_rd;
      r_hold_data  <= lu_data;
    end
  end

  // Writes to x0 are consumed as grants but never raise the write enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else if (w_grant_pipe) begin
      rf_we    <= (pipe_rd != 5'd0);
      rf_waddr <= pipe_rd;
      rf_wdata <= pipe_data;
    end else if (w_grant_hold) begin
      rf_we    <= (r_hold_rd != 5'd0);
      rf_waddr <= r_hold_rd;
      rf_wdata <= r_hold_data;
    end else begin
      rf_we    <= 1'b0;
    end
  end

endmodule
